// File: rtl/uart_rx_os16.sv
// 8N1-style UART receiver driven by a 16x oversampling strobe.
// Samples each bit at mid-bit and hands bytes out through a valid/ready holding register.
module uart_rx_os16 #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  input  logic            rx_ready,
  output logic            rx_valid,
  output logic [DBIT-1:0] rx_data,
  output logic            frame_err,
  output logic            overrun
);

  localparam int BW = $clog2(DBIT);
  localparam int SW = $clog2(SB_TICK);

  localparam logic [3:0]    TICK_MID  = 4'd7;
  localparam logic [3:0]    TICK_LAST = 4'd15;
  localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Line synchroniser; resets to the idle (high) level so reset never looks
  // like a start bit.
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_meta_d;
  logic rx_s_q, rx_s_d;

  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [3:0]      tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]   stop_cnt_q, stop_cnt_d;
  logic [DBIT-1:0] sh_q, sh_d;
  logic            frame_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      sh_q       <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      sh_q       <= sh_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    sh_d       = sh_q;
    frame_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        // s_tick is deliberately ignored here, so a tick on the detect cycle is not counted
        if (!rx_s_q) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (tick_cnt_q == TICK_MID) begin
            if (!rx_s_q) begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            sh_d       = {rx_s_q, sh_q[DBIT-1:1]};
            tick_cnt_d = '0;
            if (bit_cnt_q == BIT_LAST) begin
              state_d    = STOP;
              stop_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            frame_done = 1'b1;
            state_d    = IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Holding register
  // ---------------------------------------------------------------------------
  logic            rx_valid_q, rx_valid_d;
  logic [DBIT-1:0] rx_data_q, rx_data_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            consume;

  assign consume = rx_valid_q & rx_ready;

  always_comb begin
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;

    if (frame_done) begin
      if (!rx_valid_q || rx_ready) begin
        // Bad stop bit still delivers the byte, just flagged
        rx_data_d   = sh_q;
        frame_err_d = ~rx_s_q;
        rx_valid_d  = 1'b1;
        if (consume) overrun_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (consume) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: table of frames checked through a scoreboard, plus
// hand sequences for glitch, overrun, mid-frame reset and consume/complete overlap.
module tb_uart_rx_os16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       overrun;

  uart_rx_os16 #(.DBIT(8), .SB_TICK(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_tick    (s_tick),
    .rx        (rx),
    .rx_ready  (rx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // 16x strobe: one clk in every four
  initial begin
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      s_tick = (t == 3);
      t = (t + 1) % 4;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 64 clk per bit; a low stop bit is held only long enough to be sampled low
  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    wait_clk(64);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clk(64);
    end
    if (stop) begin
      rx = 1'b1;
      wait_clk(64);
    end else begin
      rx = 1'b0;
      wait_clk(40);
      rx = 1'b1;
      wait_clk(24);
    end
  endtask

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
  } exp_t;

  exp_t sbq[$];
  bit   mon_en = 1'b0;

  // Scoreboard consumer: one compare per accepted byte
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && rx_valid && rx_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=%0h required=none", rx_data);
        end else begin
          e = sbq.pop_front();
          check("rx_byte{data,fe,ovr}", {rx_data, frame_err, overrun}, {e.d, e.fe, 1'b0});
        end
      end
    end
  end

  typedef struct packed {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[5];
  int   n;

  initial begin
    vecs[0] = '{data: 8'h55, stop: 1'b1, exp_data: 8'h55, exp_fe: 1'b0};
    vecs[1] = '{data: 8'hA3, stop: 1'b0, exp_data: 8'hA3, exp_fe: 1'b1};
    vecs[2] = '{data: 8'h3C, stop: 1'b1, exp_data: 8'h3C, exp_fe: 1'b0};
    vecs[3] = '{data: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_fe: 1'b0};
    vecs[4] = '{data: 8'hFF, stop: 1'b1, exp_data: 8'hFF, exp_fe: 1'b0};

    // Reset state
    wait_clk(3);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    wait_clk(8);
    check("idle_valid", rx_valid, 0);

    // Frame table
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sbq.push_back('{d: vecs[i].exp_data, fe: vecs[i].exp_fe});
      send_byte(vecs[i].data, vecs[i].stop);
      wait_clk(64);
    end
    check("table_drained", sbq.size(), 0);

    // Short low glitch must not produce a byte
    rx = 1'b0;
    wait_clk(20);
    rx = 1'b1;
    wait_clk(80);
    check("glitch_valid", rx_valid, 0);
    sbq.push_back('{d: 8'h81, fe: 1'b0});
    send_byte(8'h81, 1'b1);
    wait_clk(64);
    check("glitch_drained", sbq.size(), 0);

    // Overrun: back-to-back frames with consumer stalled
    mon_en = 1'b0;
    rx_ready = 1'b0;
    send_byte(8'h11, 1'b1);
    check("ovr_first_valid", rx_valid, 1);
    check("ovr_first_ovr", overrun, 0);
    send_byte(8'h22, 1'b1);
    wait_clk(4);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_flag", overrun, 1);
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
    check("ovr_consumed_valid", rx_valid, 0);
    check("ovr_consumed_flag", overrun, 0);

    // Mid-frame async reset with a full holding register and overrun set
    send_byte(8'h5A, 1'b1);
    send_byte(8'h5B, 1'b1);
    check("pre_rst_overrun", overrun, 1);
    rx = 1'b0;
    wait_clk(64);
    rx = 1'b1;
    wait_clk(100);
    reset = 1'b1;
    #1;
    check("async_rst_valid", rx_valid, 0);
    check("async_rst_data", rx_data, 0);
    check("async_rst_overrun", overrun, 0);
    wait_clk(3);
    reset = 1'b0;
    wait_clk(600);
    rx_ready = 1'b1;
    mon_en = 1'b1;
    sbq.push_back('{d: 8'h0F, fe: 1'b0});
    send_byte(8'h0F, 1'b1);
    wait_clk(64);
    check("post_rst_drained", sbq.size(), 0);

    // Consume coinciding with completion; first learn the completion offset
    mon_en = 1'b0;
    rx_ready = 1'b0;
    send_byte(8'h66, 1'b1);
    check("coinc_hold_data", rx_data, 8'h66);
    n = 0;
    fork
      send_byte(8'h99, 1'b1);
      begin
        while (!overrun && n < 700) begin
          @(negedge clk);
          n++;
        end
      end
    join
    check("coinc_measure_ovr", overrun, 1);
    if (n > 1 && n < 700) begin
      fork
        send_byte(8'h77, 1'b1);
        begin
          wait_clk(n - 1);
          rx_ready = 1'b1;
          @(negedge clk);
          rx_ready = 1'b0;
          check("coinc_valid", rx_valid, 1);
          check("coinc_data", rx_data, 8'h77);
          check("coinc_overrun", overrun, 0);
        end
      join
    end else begin
      checks++;
      failures++;
      $display("FAIL coinc_timeout actual=%0d required=<700", n);
    end
    rx_ready = 1'b1;
    wait_clk(4);
    check("final_valid", rx_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
